// File: rtl/valu_wb_queue_pkg.sv
// Shared definitions for the VALU writeback queue: FSM states, entry field widths and the
// bit offsets used to pack a captured result into one FIFO word.
package valu_wb_queue_pkg;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_VGPR   = 2'd1,
    WB_SGPR   = 2'd2,
    WB_RETIRE = 2'd3
  } wb_state_e;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned LANES  = 16;
  localparam int unsigned WFID_W = 6;

  // Fixed-width fields sit at the bottom; the two address fields follow at parameter widths.
  localparam int unsigned DATA_OFF  = 0;
  localparam int unsigned MASK_OFF  = DATA_OFF + DATA_W;
  localparam int unsigned VCC_OFF   = MASK_OFF + LANES;
  localparam int unsigned WFID_OFF  = VCC_OFF + LANES;
  localparam int unsigned VEN_OFF   = WFID_OFF + WFID_W;
  localparam int unsigned SEN_OFF   = VEN_OFF + 1;
  localparam int unsigned VADDR_OFF = SEN_OFF + 1;

  function automatic int unsigned entry_w(int unsigned vaddr_w, int unsigned saddr_w);
    return VADDR_OFF + vaddr_w + saddr_w;
  endfunction

endpackage

// File: rtl/valu_wb_queue_if.sv
// VALU result capture, VGPR/SGPR write ports and retire/back-pressure signals.
// master = writeback queue side, slave = VALU / register file / issue side.
interface valu_wb_queue_if #(
  parameter int unsigned VADDR_W = 10,
  parameter int unsigned SADDR_W = 9
);
  import valu_wb_queue_pkg::*;

  logic                valu_done;
  logic [DATA_W-1:0]   alu_vgpr_dest_data;
  logic [LANES-1:0]    alu_dest_vcc_value;
  logic [LANES-1:0]    alu_dest_exec_value;
  logic [WFID_W-1:0]   tag_wfid;
  logic [VADDR_W-1:0]  tag_vgpr_addr;
  logic                tag_vgpr_en;
  logic [SADDR_W-1:0]  tag_sgpr_addr;
  logic                tag_sgpr_en;

  logic                vgpr_wr_req;
  logic [VADDR_W-1:0]  vgpr_wr_addr;
  logic [DATA_W-1:0]   vgpr_wr_data;
  logic [LANES-1:0]    vgpr_wr_mask;
  logic                vgpr_wr_ack;

  logic                sgpr_wr_req;
  logic [SADDR_W-1:0]  sgpr_wr_addr;
  logic [LANES-1:0]    sgpr_wr_data;
  logic                sgpr_wr_ack;

  logic                retire_valid;
  logic [WFID_W-1:0]   retire_wfid;
  logic                wb_full;

  modport master (
    input  valu_done, alu_vgpr_dest_data, alu_dest_vcc_value, alu_dest_exec_value,
    input  tag_wfid, tag_vgpr_addr, tag_vgpr_en, tag_sgpr_addr, tag_sgpr_en,
    output vgpr_wr_req, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
    input  vgpr_wr_ack,
    output sgpr_wr_req, sgpr_wr_addr, sgpr_wr_data,
    input  sgpr_wr_ack,
    output retire_valid, retire_wfid, wb_full
  );

  modport slave (
    output valu_done, alu_vgpr_dest_data, alu_dest_vcc_value, alu_dest_exec_value,
    output tag_wfid, tag_vgpr_addr, tag_vgpr_en, tag_sgpr_addr, tag_sgpr_en,
    input  vgpr_wr_req, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
    output vgpr_wr_ack,
    input  sgpr_wr_req, sgpr_wr_addr, sgpr_wr_data,
    output sgpr_wr_ack,
    input  retire_valid, retire_wfid, wb_full
  );

endinterface

// File: rtl/valu_wb_fifo.sv
// Generic DEPTH x WIDTH register FIFO. Push and pop may coincide at any occupancy; a push
// into a full FIFO without a pop is dropped.
module valu_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_q | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/valu_wb_queue.sv
// VALU writeback queue: captures results on valu_done rising, drains each entry as a VGPR
// then SGPR write and retires it. Optional perf counters under VALU_WB_PERF_EN.
module valu_wb_queue
  import valu_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned VADDR_W = 10,
  parameter int unsigned SADDR_W = 9
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VALU_WB_PERF_EN
  output logic [31:0] perf_retired_o,
  output logic [31:0] perf_stall_o,
`endif
  valu_wb_queue_if.master bus_io
);

  localparam int unsigned EntryW   = entry_w(VADDR_W, SADDR_W);
  localparam int unsigned SaddrOff = VADDR_OFF + VADDR_W;
  localparam int unsigned CntW     = $clog2(DEPTH) + 1;

  logic              valu_done_q;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [EntryW-1:0] entry_in, head;
  logic              ovf_err_q;

  logic [DATA_W-1:0]  head_data;
  logic [LANES-1:0]   head_mask, head_vcc;
  logic [WFID_W-1:0]  head_wfid;
  logic               head_ven, head_sen;
  logic [VADDR_W-1:0] head_vaddr;
  logic [SADDR_W-1:0] head_saddr;

  wb_state_e          state_q;
  logic               vgpr_req_q, sgpr_req_q, retire_valid_q;
  logic [VADDR_W-1:0] vgpr_addr_q;
  logic [DATA_W-1:0]  vgpr_data_q;
  logic [LANES-1:0]   vgpr_mask_q, sgpr_data_q;
  logic [SADDR_W-1:0] sgpr_addr_q;
  logic [WFID_W-1:0]  retire_wfid_q;

  assign push = bus_io.valu_done & ~valu_done_q;
  assign pop  = (state_q == WB_RETIRE);

  always_comb begin
    entry_in = '0;
    entry_in[DATA_OFF +: DATA_W]   = bus_io.alu_vgpr_dest_data;
    entry_in[MASK_OFF +: LANES]    = bus_io.alu_dest_exec_value;
    entry_in[VCC_OFF +: LANES]     = bus_io.alu_dest_vcc_value;
    entry_in[WFID_OFF +: WFID_W]   = bus_io.tag_wfid;
    entry_in[VEN_OFF]              = bus_io.tag_vgpr_en;
    entry_in[SEN_OFF]              = bus_io.tag_sgpr_en;
    entry_in[VADDR_OFF +: VADDR_W] = bus_io.tag_vgpr_addr;
    entry_in[SaddrOff +: SADDR_W]  = bus_io.tag_sgpr_addr;
  end

  assign head_data  = head[DATA_OFF +: DATA_W];
  assign head_mask  = head[MASK_OFF +: LANES];
  assign head_vcc   = head[VCC_OFF +: LANES];
  assign head_wfid  = head[WFID_OFF +: WFID_W];
  assign head_ven   = head[VEN_OFF];
  assign head_sen   = head[SEN_OFF];
  assign head_vaddr = head[VADDR_OFF +: VADDR_W];
  assign head_saddr = head[SaddrOff +: SADDR_W];

  valu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (entry_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valu_done_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      valu_done_q <= bus_io.valu_done;
      if (push && fifo_full && !pop) ovf_err_q <= 1'b1;
    end
  end

  // Head entry is not popped until RETIRE, so it stays valid across VGPR and SGPR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WB_IDLE;
      vgpr_req_q     <= 1'b0;
      vgpr_addr_q    <= '0;
      vgpr_data_q    <= '0;
      vgpr_mask_q    <= '0;
      sgpr_req_q     <= 1'b0;
      sgpr_addr_q    <= '0;
      sgpr_data_q    <= '0;
      retire_valid_q <= 1'b0;
      retire_wfid_q  <= '0;
    end else begin
      retire_valid_q <= 1'b0;
      unique case (state_q)
        WB_IDLE: begin
          if (!fifo_empty) begin
            if (head_ven) begin
              state_q     <= WB_VGPR;
              vgpr_req_q  <= 1'b1;
              vgpr_addr_q <= head_vaddr;
              vgpr_data_q <= head_data;
              vgpr_mask_q <= head_mask;
            end else if (head_sen) begin
              state_q     <= WB_SGPR;
              sgpr_req_q  <= 1'b1;
              sgpr_addr_q <= head_saddr;
              sgpr_data_q <= head_vcc;
            end else begin
              state_q        <= WB_RETIRE;
              retire_valid_q <= 1'b1;
              retire_wfid_q  <= head_wfid;
            end
          end
        end
        WB_VGPR: begin
          if (bus_io.vgpr_wr_ack) begin
            vgpr_req_q <= 1'b0;
            if (head_sen) begin
              state_q     <= WB_SGPR;
              sgpr_req_q  <= 1'b1;
              sgpr_addr_q <= head_saddr;
              sgpr_data_q <= head_vcc;
            end else begin
              state_q        <= WB_RETIRE;
              retire_valid_q <= 1'b1;
              retire_wfid_q  <= head_wfid;
            end
          end
        end
        WB_SGPR: begin
          if (bus_io.sgpr_wr_ack) begin
            sgpr_req_q     <= 1'b0;
            state_q        <= WB_RETIRE;
            retire_valid_q <= 1'b1;
            retire_wfid_q  <= head_wfid;
          end
        end
        WB_RETIRE: state_q <= WB_IDLE;
        default:   state_q <= WB_IDLE;
      endcase
    end
  end

  assign bus_io.vgpr_wr_req  = vgpr_req_q;
  assign bus_io.vgpr_wr_addr = vgpr_addr_q;
  assign bus_io.vgpr_wr_data = vgpr_data_q;
  assign bus_io.vgpr_wr_mask = vgpr_mask_q;
  assign bus_io.sgpr_wr_req  = sgpr_req_q;
  assign bus_io.sgpr_wr_addr = sgpr_addr_q;
  assign bus_io.sgpr_wr_data = sgpr_data_q;
  assign bus_io.retire_valid = retire_valid_q;
  assign bus_io.retire_wfid  = retire_wfid_q;
  assign bus_io.wb_full      = fifo_full;

`ifdef VALU_WB_PERF_EN
  logic [31:0] perf_retired_q, perf_stall_q;
  logic        stall;

  assign stall = (vgpr_req_q & ~bus_io.vgpr_wr_ack) | (sgpr_req_q & ~bus_io.sgpr_wr_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (retire_valid_q && (perf_retired_q != '1)) perf_retired_q <= perf_retired_q + 32'd1;
      if (stall && (perf_stall_q != '1))            perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_valu_wb_queue.sv
// Self-checking bench for valu_wb_queue: random ops checked against an in-order queue model.
// Perf counter scenario is compiled in when VALU_WB_PERF_EN is defined.
module tb_valu_wb_queue;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned VADDR_W = 10;
  localparam int unsigned SADDR_W = 9;

  typedef struct {
    logic [511:0] data;
    logic [15:0]  vcc;
    logic [15:0]  exec;
    logic [5:0]   wfid;
    logic [9:0]   vaddr;
    logic         ven;
    logic [8:0]   saddr;
    logic         sen;
  } op_t;

  typedef struct {
    logic [9:0]   addr;
    logic [511:0] data;
    logic [15:0]  mask;
  } vwr_t;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } swr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  valu_wb_queue_if #(.VADDR_W(VADDR_W), .SADDR_W(SADDR_W)) bus ();

`ifdef VALU_WB_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  valu_wb_queue #(
    .DEPTH   (DEPTH),
    .VADDR_W (VADDR_W),
    .SADDR_W (SADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef VALU_WB_PERF_EN
    .perf_retired_o (perf_retired),
    .perf_stall_o   (perf_stall),
`endif
    .bus_io         (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vwr_t       obs_v[$];
  swr_t       obs_s[$];
  logic [5:0] obs_r[$];
  int         obs_r_cyc[$];

  // Ack policy: 0 low, 1 high, 2 random, 3 scheduled stalls per VGPR request.
  int vack_mode = 0;
  int sack_mode = 0;
  int vstall_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int  vcur;
    bit  vin;
    vcur = 0;
    vin  = 1'b0;
    bus.vgpr_wr_ack = 1'b0;
    bus.sgpr_wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      case (vack_mode)
        0: bus.vgpr_wr_ack = 1'b0;
        1: bus.vgpr_wr_ack = 1'b1;
        2: bus.vgpr_wr_ack = 1'($urandom_range(0, 1));
        default: begin
          if (bus.vgpr_wr_req) begin
            if (!vin) begin
              vin  = 1'b1;
              vcur = (vstall_q.size() > 0) ? vstall_q.pop_front() : 0;
            end
            if (vcur > 0) begin
              bus.vgpr_wr_ack = 1'b0;
              vcur--;
            end else begin
              bus.vgpr_wr_ack = 1'b1;
            end
          end else begin
            vin = 1'b0;
            bus.vgpr_wr_ack = 1'($urandom_range(0, 1));
          end
        end
      endcase
      case (sack_mode)
        0: bus.sgpr_wr_ack = 1'b0;
        1: bus.sgpr_wr_ack = 1'b1;
        default: bus.sgpr_wr_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: req/ack are stable from just after negedge until the next posedge.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.vgpr_wr_req && bus.vgpr_wr_ack)
        obs_v.push_back('{bus.vgpr_wr_addr, bus.vgpr_wr_data, bus.vgpr_wr_mask});
      if (bus.sgpr_wr_req && bus.sgpr_wr_ack)
        obs_s.push_back('{bus.sgpr_wr_addr, bus.sgpr_wr_data});
      if (bus.retire_valid) begin
        obs_r.push_back(bus.retire_wfid);
        obs_r_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.data  = rand512();
    o.vcc   = 16'($urandom);
    o.exec  = 16'($urandom);
    o.wfid  = 6'($urandom);
    o.vaddr = 10'($urandom);
    o.ven   = 1'($urandom_range(0, 1));
    o.saddr = 9'($urandom);
    o.sen   = 1'($urandom_range(0, 1));
    return o;
  endfunction

  task automatic scramble();
    bus.alu_vgpr_dest_data  = rand512();
    bus.alu_dest_vcc_value  = 16'($urandom);
    bus.alu_dest_exec_value = 16'($urandom);
    bus.tag_wfid            = 6'($urandom);
    bus.tag_vgpr_addr       = 10'($urandom);
    bus.tag_vgpr_en         = 1'($urandom_range(0, 1));
    bus.tag_sgpr_addr       = 9'($urandom);
    bus.tag_sgpr_en         = 1'($urandom_range(0, 1));
  endtask

  // Drives op for 'hold' cycles; inputs are scrambled after the first (capturing) edge.
  task automatic issue(input op_t op, input int hold, output int start);
    @(negedge clk);
    start = cyc;
    bus.alu_vgpr_dest_data  = op.data;
    bus.alu_dest_vcc_value  = op.vcc;
    bus.alu_dest_exec_value = op.exec;
    bus.tag_wfid            = op.wfid;
    bus.tag_vgpr_addr       = op.vaddr;
    bus.tag_vgpr_en         = op.ven;
    bus.tag_sgpr_addr       = op.saddr;
    bus.tag_sgpr_en         = op.sen;
    bus.valu_done           = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
    end
    bus.valu_done = 1'b0;
  endtask

  task automatic wait_retires(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (obs_r.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_obs();
    obs_v.delete();
    obs_s.delete();
    obs_r.delete();
    obs_r_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valu_done = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (bus.vgpr_wr_req !== 1'b0 || bus.sgpr_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: vreq=%b sreq=%b expected 0 0", bus.vgpr_wr_req, bus.sgpr_wr_req);
    end
    checks++;
    if (bus.retire_valid !== 1'b0 || bus.wb_full !== 1'b0 || bus.retire_wfid !== 6'd0) begin
      errors++;
      $display("FAIL reset_retire: rv=%b full=%b wfid=%h expected 0 0 0",
               bus.retire_valid, bus.wb_full, bus.retire_wfid);
    end
    checks++;
    if (bus.vgpr_wr_data !== 512'd0 || bus.vgpr_wr_mask !== 16'd0 ||
        bus.vgpr_wr_addr !== 10'd0 || bus.sgpr_wr_data !== 16'd0 || bus.sgpr_wr_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_data: vaddr=%h vmask=%h saddr=%h sdata=%h expected all 0",
               bus.vgpr_wr_addr, bus.vgpr_wr_mask, bus.sgpr_wr_addr, bus.sgpr_wr_data);
    end
`ifdef VALU_WB_PERF_EN
    checks++;
    if (perf_retired !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: retired=%0d stall=%0d expected 0 0", perf_retired, perf_stall);
    end
`endif
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_single_vgpr();
    op_t op;
    int  start;
    bit  ok;
    vack_mode = 1;
    sack_mode = 1;
    clear_obs();
    op = rand_op();
    op.ven  = 1'b1;
    op.sen  = 1'b0;
    op.exec = 16'hFFFF;
    issue(op, 1, start);
    wait_retires(1, 30, ok);
    repeat (5) @(negedge clk);
    #3;
    checks++;
    if (!ok || obs_r.size() != 1 || obs_v.size() != 1 || obs_s.size() != 0) begin
      errors++;
      $display("FAIL single_counts: retires=%0d vwr=%0d swr=%0d expected 1 1 0",
               obs_r.size(), obs_v.size(), obs_s.size());
    end else begin
      checks++;
      if (obs_v[0].addr !== op.vaddr || obs_v[0].mask !== 16'hFFFF) begin
        errors++;
        $display("FAIL single_addr_mask: addr=%h mask=%h expected %h FFFF",
                 obs_v[0].addr, obs_v[0].mask, op.vaddr);
      end
      checks++;
      if (obs_v[0].data !== op.data) begin
        errors++;
        $display("FAIL single_data: got %h expected %h", obs_v[0].data, op.data);
      end
      checks++;
      if (obs_r[0] !== op.wfid) begin
        errors++;
        $display("FAIL single_wfid: got %h expected %h", obs_r[0], op.wfid);
      end
      checks++;
      if (obs_r_cyc[0] - start != 3) begin
        errors++;
        $display("FAIL single_latency: got %0d expected 3", obs_r_cyc[0] - start);
      end
    end
  endtask

  task automatic test_held_done();
    op_t op;
    int  start;
    bit  ok;
    vack_mode = 1;
    sack_mode = 1;
    clear_obs();
    op = rand_op();
    op.ven = 1'b1;
    op.sen = 1'b1;
    issue(op, 10, start);
    wait_retires(1, 30, ok);
    repeat (10) @(negedge clk);
    #3;
    checks++;
    if (!ok || obs_r.size() != 1 || obs_v.size() != 1 || obs_s.size() != 1) begin
      errors++;
      $display("FAIL held_counts: retires=%0d vwr=%0d swr=%0d expected 1 1 1",
               obs_r.size(), obs_v.size(), obs_s.size());
    end else begin
      checks++;
      if (obs_r_cyc[0] - start != 4) begin
        errors++;
        $display("FAIL held_latency: got %0d expected 4", obs_r_cyc[0] - start);
      end
      checks++;
      if (obs_s[0].data !== op.vcc || obs_s[0].addr !== op.saddr) begin
        errors++;
        $display("FAIL held_sgpr: addr=%h data=%h expected %h %h",
                 obs_s[0].addr, obs_s[0].data, op.saddr, op.vcc);
      end
    end
  endtask

  task automatic test_ack_withheld();
    op_t op;
    int  start;
    bit  ok, seen, unstable, early;
    vack_mode = 0;
    sack_mode = 1;
    clear_obs();
    op = rand_op();
    op.ven = 1'b1;
    op.sen = 1'b1;
    op.vcc = 16'hA5A5;
    issue(op, 1, start);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #3;
      seen = bus.vgpr_wr_req;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL withheld_req_rise: vgpr_wr_req=0 expected 1 within 10 cycles");
    end
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #3;
      end
      if (bus.vgpr_wr_req !== 1'b1 || bus.vgpr_wr_data !== op.data ||
          bus.vgpr_wr_addr !== op.vaddr || bus.vgpr_wr_mask !== op.exec ||
          bus.sgpr_wr_req !== 1'b0) unstable = 1'b1;
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL withheld_stable: vreq=%b sreq=%b addr=%h expected 1 0 %h",
               bus.vgpr_wr_req, bus.sgpr_wr_req, bus.vgpr_wr_addr, op.vaddr);
    end
    vack_mode = 1;
    early = 1'b0;
    ok    = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #3;
      if (bus.sgpr_wr_req && obs_v.size() == 0) early = 1'b1;
      ok = (obs_r.size() >= 1);
    end
    checks++;
    if (early || !ok) begin
      errors++;
      $display("FAIL withheld_order: early_sgpr=%b retired=%b expected 0 1", early, ok);
    end
    checks++;
    if (obs_s.size() != 1 || obs_s[0].data !== 16'hA5A5) begin
      errors++;
      $display("FAIL withheld_vcc: swr=%0d data=%h expected 1 a5a5",
               obs_s.size(), (obs_s.size() > 0) ? obs_s[0].data : 16'h0);
    end
  endtask

  task automatic test_overflow();
    op_t o[3];
    int  start;
    bit  ok;
    vack_mode = 0;
    sack_mode = 0;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      o[i] = rand_op();
      if (!o[i].ven) o[i].sen = 1'b1;
      o[i].wfid = 6'(10 + i);
    end
    issue(o[0], 1, start);
    issue(o[1], 1, start);
    #3;
    checks++;
    if (bus.wb_full !== 1'b1 || dut.ovf_err_q !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: full=%b ovf=%b expected 1 0", bus.wb_full, dut.ovf_err_q);
    end
    issue(o[2], 1, start);
    #3;
    checks++;
    if (dut.ovf_err_q !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%b expected 1", dut.ovf_err_q);
    end
    vack_mode = 2;
    sack_mode = 2;
    wait_retires(2, 200, ok);
    repeat (30) @(negedge clk);
    #3;
    checks++;
    if (!ok || obs_r.size() != 2) begin
      errors++;
      $display("FAIL ovf_retire_count: got %0d expected 2", obs_r.size());
    end else begin
      checks++;
      if (obs_r[0] !== o[0].wfid || obs_r[1] !== o[1].wfid) begin
        errors++;
        $display("FAIL ovf_order: got %h %h expected %h %h",
                 obs_r[0], obs_r[1], o[0].wfid, o[1].wfid);
      end
    end
    checks++;
    if (bus.wb_full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained_full: full=%b expected 0", bus.wb_full);
    end
  endtask

  task automatic test_reset_mid_write();
    op_t a, b;
    int  start;
    bit  seen;
    vack_mode = 0;
    sack_mode = 0;
    a = rand_op();
    a.ven = 1'b1;
    b = rand_op();
    b.ven = 1'b1;
    issue(a, 1, start);
    issue(b, 1, start);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #3;
      seen = bus.vgpr_wr_req;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (!seen || bus.vgpr_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_drop: seen=%b vreq=%b expected 1 0", seen, bus.vgpr_wr_req);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    #3;
    checks++;
    if (dut.fifo_count !== '0 || bus.wb_full !== 1'b0 || dut.ovf_err_q !== 1'b0) begin
      errors++;
      $display("FAIL rst_state: count=%0d full=%b ovf=%b expected 0 0 0",
               dut.fifo_count, bus.wb_full, dut.ovf_err_q);
    end
    vack_mode = 1;
    sack_mode = 1;
    repeat (20) @(negedge clk);
    #3;
    checks++;
    if (obs_r.size() != 0 || obs_v.size() != 0 || obs_s.size() != 0) begin
      errors++;
      $display("FAIL rst_no_retire: retires=%0d vwr=%0d swr=%0d expected 0 0 0",
               obs_r.size(), obs_v.size(), obs_s.size());
    end
  endtask

  task automatic test_random();
    op_t acc[$];
    vwr_t exp_v[$];
    swr_t exp_s[$];
    int   start;
    bit   ok, gate_ok;
    vack_mode = 2;
    sack_mode = 2;
    clear_obs();
    gate_ok = 1'b1;
    for (int n = 0; n < 24; n++) begin
      op_t op;
      bit  free;
      op = rand_op();
      free = 1'b0;
      for (int i = 0; i < 200 && !free; i++) begin
        @(negedge clk);
        #3;
        free = !bus.wb_full;
      end
      if (!free) gate_ok = 1'b0;
      acc.push_back(op);
      issue(op, $urandom_range(1, 3), start);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    checks++;
    if (!gate_ok) begin
      errors++;
      $display("FAIL rand_full_stuck: wb_full held for 200 cycles");
    end
    wait_retires(acc.size(), 3000, ok);
    repeat (10) @(negedge clk);
    #3;
    foreach (acc[i]) begin
      if (acc[i].ven) exp_v.push_back('{acc[i].vaddr, acc[i].data, acc[i].exec});
      if (acc[i].sen) exp_s.push_back('{acc[i].saddr, acc[i].vcc});
    end
    checks++;
    if (!ok || obs_r.size() != acc.size() || obs_v.size() != exp_v.size() ||
        obs_s.size() != exp_s.size()) begin
      errors++;
      $display("FAIL rand_counts: retires=%0d/%0d vwr=%0d/%0d swr=%0d/%0d (got/expected)",
               obs_r.size(), acc.size(), obs_v.size(), exp_v.size(), obs_s.size(), exp_s.size());
    end else begin
      foreach (acc[i]) begin
        checks++;
        if (obs_r[i] !== acc[i].wfid) begin
          errors++;
          $display("FAIL rand_retire[%0d]: got %h expected %h", i, obs_r[i], acc[i].wfid);
        end
      end
      foreach (exp_v[i]) begin
        checks++;
        if (obs_v[i].addr !== exp_v[i].addr || obs_v[i].mask !== exp_v[i].mask ||
            obs_v[i].data !== exp_v[i].data) begin
          errors++;
          $display("FAIL rand_vgpr[%0d]: addr=%h mask=%h expected %h %h", i,
                   obs_v[i].addr, obs_v[i].mask, exp_v[i].addr, exp_v[i].mask);
        end
      end
      foreach (exp_s[i]) begin
        checks++;
        if (obs_s[i].addr !== exp_s[i].addr || obs_s[i].data !== exp_s[i].data) begin
          errors++;
          $display("FAIL rand_sgpr[%0d]: addr=%h data=%h expected %h %h", i,
                   obs_s[i].addr, obs_s[i].data, exp_s[i].addr, exp_s[i].data);
        end
      end
    end
  endtask

`ifdef VALU_WB_PERF_EN
  task automatic test_perf();
    int start;
    bit ok;
    vack_mode = 1;
    sack_mode = 1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    vstall_q = '{2, 1, 3, 1};
    vack_mode = 3;
    for (int n = 0; n < 4; n++) begin
      op_t op;
      bit  free;
      op = rand_op();
      op.ven = 1'b1;
      op.sen = 1'b0;
      free = 1'b0;
      for (int i = 0; i < 200 && !free; i++) begin
        @(negedge clk);
        #3;
        free = !bus.wb_full;
      end
      issue(op, 1, start);
    end
    wait_retires(4, 300, ok);
    repeat (5) @(negedge clk);
    #3;
    checks++;
    if (!ok || perf_retired !== 32'd4) begin
      errors++;
      $display("FAIL perf_retired: got %0d expected 4", perf_retired);
    end
    checks++;
    if (perf_stall !== 32'd7) begin
      errors++;
      $display("FAIL perf_stall: got %0d expected 7", perf_stall);
    end
  endtask
`endif

  initial begin
    bus.valu_done = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single_vgpr();
    test_held_done();
    test_ack_withheld();
    test_overflow();
    test_reset_mid_write();
    test_random();
`ifdef VALU_WB_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
